// File: rtl/rob_if.sv
// Reorder buffer port bundle: dispatch handshake, completion tags, retire
// outputs and occupancy status.
interface rob_if #(
    parameter int TAG_W = 4
);
    logic             dispatch_valid;
    logic             dispatch_has_rd;
    logic [4:0]       dispatch_rd;
    logic [5:0]       dispatch_phys_rd;
    logic [5:0]       dispatch_old_phys_rd;
    logic             dispatch_ready;
    logic [TAG_W-1:0] dispatch_tag;
    logic             complete_valid;
    logic [TAG_W-1:0] complete_tag;
    logic             retire_valid;
    logic [5:0]       retire_phys_reg;
    logic [4:0]       retire_arch_reg;
    logic [5:0]       retire_new_phys;
    logic             retire_inst;
    logic [TAG_W:0]   rob_count;
    logic             rob_empty;
    logic             rob_full;

    // Rename/issue/execute side: drives dispatch and completion.
    modport master (
        output dispatch_valid, dispatch_has_rd, dispatch_rd,
               dispatch_phys_rd, dispatch_old_phys_rd,
               complete_valid, complete_tag,
        input  dispatch_ready, dispatch_tag,
               retire_valid, retire_phys_reg, retire_arch_reg,
               retire_new_phys, retire_inst,
               rob_count, rob_empty, rob_full
    );

    // Reorder buffer side.
    modport slave (
        input  dispatch_valid, dispatch_has_rd, dispatch_rd,
               dispatch_phys_rd, dispatch_old_phys_rd,
               complete_valid, complete_tag,
        output dispatch_ready, dispatch_tag,
               retire_valid, retire_phys_reg, retire_arch_reg,
               retire_new_phys, retire_inst,
               rob_count, rob_empty, rob_full
    );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement queue. Entries are written at the tail in program
// order, marked done by out-of-order completion tags, and retired from the
// head one per cycle. Retire outputs are registered so the rename unit can
// sample them on its falling edge.
module reorder_buffer #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 4
) (
    input  logic  clk,
    input  logic  reset_n,
    rob_if.slave  rob
);

    // Pointer increment; DEPTH is a power of two so the natural overflow of
    // a TAG_W-bit value is the modulo-DEPTH wrap.
    function automatic logic [TAG_W-1:0] ptr_inc(input logic [TAG_W-1:0] p);
        return p + TAG_W'(1);
    endfunction

    // Per-entry state
    logic [DEPTH-1:0] valid_r;
    logic [DEPTH-1:0] done_r;
    logic [DEPTH-1:0] has_rd_r;
    logic [4:0]       rd_r       [DEPTH];
    logic [5:0]       phys_r     [DEPTH];
    logic [5:0]       old_phys_r [DEPTH];

    // Pointers and occupancy
    logic [TAG_W-1:0] head_r;
    logic [TAG_W-1:0] tail_r;
    logic [TAG_W:0]   count_r;

    // Registered retire outputs
    logic             retire_valid_r;
    logic             retire_inst_r;
    logic [5:0]       retire_phys_reg_r;
    logic [4:0]       retire_arch_reg_r;
    logic [5:0]       retire_new_phys_r;

    // Decoded events for this cycle
    logic full_s;
    logic empty_s;
    logic dispatch_fire_s;
    logic complete_fire_s;
    logic retire_fire_s;

    // Decode occupancy and the three per-cycle events from pre-edge state.
    // Readiness deliberately ignores a same-cycle retire.
    always_comb begin
        full_s          = (count_r == (TAG_W+1)'(DEPTH));
        empty_s         = (count_r == (TAG_W+1)'(0));
        dispatch_fire_s = rob.dispatch_valid && !full_s;
        complete_fire_s = rob.complete_valid && valid_r[rob.complete_tag];
        retire_fire_s   = valid_r[head_r] && done_r[head_r];
    end

    // Entry array: completion sets done, retire clears the head, dispatch
    // writes the tail. Retire clears after a same-cycle completion of the
    // head so the slot is left clean; dispatch never targets the head slot
    // while it is valid because that would require the queue to be full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_r  <= {DEPTH{1'b0}};
            done_r   <= {DEPTH{1'b0}};
            has_rd_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                rd_r[i]       <= 5'd0;
                phys_r[i]     <= 6'd0;
                old_phys_r[i] <= 6'd0;
            end
        end else begin
            if (complete_fire_s) begin
                done_r[rob.complete_tag] <= 1'b1;
            end
            if (retire_fire_s) begin
                valid_r[head_r] <= 1'b0;
                done_r[head_r]  <= 1'b0;
            end
            if (dispatch_fire_s) begin
                valid_r[tail_r]    <= 1'b1;
                done_r[tail_r]     <= 1'b0;
                has_rd_r[tail_r]   <= rob.dispatch_has_rd;
                rd_r[tail_r]       <= rob.dispatch_rd;
                phys_r[tail_r]     <= rob.dispatch_phys_rd;
                old_phys_r[tail_r] <= rob.dispatch_old_phys_rd;
            end
        end
    end

    // Head/tail pointers and entry count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_r  <= {TAG_W{1'b0}};
            tail_r  <= {TAG_W{1'b0}};
            count_r <= {(TAG_W+1){1'b0}};
        end else begin
            if (dispatch_fire_s) begin
                tail_r <= ptr_inc(tail_r);
            end
            if (retire_fire_s) begin
                head_r <= ptr_inc(head_r);
            end
            case ({dispatch_fire_s, retire_fire_s})
                2'b10:   count_r <= count_r + (TAG_W+1)'(1);
                2'b01:   count_r <= count_r - (TAG_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Retire outputs: one-cycle pulses, data loaded on retire and held
    // otherwise so the free list sees a stable value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retire_valid_r    <= 1'b0;
            retire_inst_r     <= 1'b0;
            retire_phys_reg_r <= 6'd0;
            retire_arch_reg_r <= 5'd0;
            retire_new_phys_r <= 6'd0;
        end else if (retire_fire_s) begin
            retire_valid_r    <= has_rd_r[head_r];
            retire_inst_r     <= 1'b1;
            retire_phys_reg_r <= old_phys_r[head_r];
            retire_arch_reg_r <= rd_r[head_r];
            retire_new_phys_r <= phys_r[head_r];
        end else begin
            retire_valid_r <= 1'b0;
            retire_inst_r  <= 1'b0;
        end
    end

    assign rob.dispatch_ready  = !full_s;
    assign rob.dispatch_tag    = tail_r;
    assign rob.rob_count       = count_r;
    assign rob.rob_empty       = empty_s;
    assign rob.rob_full        = full_s;
    assign rob.retire_valid    = retire_valid_r;
    assign rob.retire_inst     = retire_inst_r;
    assign rob.retire_phys_reg = retire_phys_reg_r;
    assign rob.retire_arch_reg = retire_arch_reg_r;
    assign rob.retire_new_phys = retire_new_phys_r;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a program-order queue model checked on
// every falling edge, plus literal expectations at key points.
module tb_reorder_buffer;
    localparam int DEPTH = 16;
    localparam int TAG_W = 4;

    logic clk;
    logic reset_n;
    int   tests;
    int   fails;
    bit   check_en;

    rob_if #(.TAG_W(TAG_W)) rob ();

    reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rob     (rob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [TAG_W-1:0] tag;
        logic             has_rd;
        logic [4:0]       rd;
        logic [5:0]       phys;
        logic [5:0]       old;
        logic             done;
    } ent_t;

    ent_t             q[$];
    ent_t             e;
    logic [TAG_W-1:0] m_tag;
    logic             m_rv, m_ri;
    logic [5:0]       m_rp, m_rn;
    logic [4:0]       m_ra;
    bit               m_can, m_ret;

    initial begin
        q.delete();
        m_tag = '0; m_rv = 1'b0; m_ri = 1'b0; m_rp = '0; m_rn = '0; m_ra = '0;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                q.delete();
                m_tag = '0; m_rv = 1'b0; m_ri = 1'b0;
                m_rp = '0; m_rn = '0; m_ra = '0;
            end else begin
                m_can = (q.size() < DEPTH);
                m_ret = (q.size() > 0) && q[0].done;
                if (rob.complete_valid) begin
                    foreach (q[i]) if (q[i].tag == rob.complete_tag) q[i].done = 1'b1;
                end
                if (m_ret) begin
                    e = q.pop_front();
                    m_rv = e.has_rd; m_ri = 1'b1;
                    m_rp = e.old; m_ra = e.rd; m_rn = e.phys;
                end else begin
                    m_rv = 1'b0; m_ri = 1'b0;
                end
                if (rob.dispatch_valid && m_can) begin
                    e.tag = m_tag; e.has_rd = rob.dispatch_has_rd;
                    e.rd = rob.dispatch_rd; e.phys = rob.dispatch_phys_rd;
                    e.old = rob.dispatch_old_phys_rd; e.done = 1'b0;
                    q.push_back(e);
                    m_tag = m_tag + 4'd1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                check("m_ready", 32'(rob.dispatch_ready), 32'(q.size() < DEPTH));
                check("m_tag",   32'(rob.dispatch_tag),   32'(m_tag));
                check("m_count", 32'(rob.rob_count),      32'(q.size()));
                check("m_empty", 32'(rob.rob_empty),      32'(q.size() == 0));
                check("m_full",  32'(rob.rob_full),       32'(q.size() == DEPTH));
                check("m_rv",    32'(rob.retire_valid),   32'(m_rv));
                check("m_ri",    32'(rob.retire_inst),    32'(m_ri));
                check("m_rp",    32'(rob.retire_phys_reg), 32'(m_rp));
                check("m_ra",    32'(rob.retire_arch_reg), 32'(m_ra));
                check("m_rn",    32'(rob.retire_new_phys), 32'(m_rn));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rob.dispatch_valid = 1'b0;
        rob.complete_valid = 1'b0;
    endtask

    task automatic disp(input logic has_rd, input logic [4:0] rd,
                        input logic [5:0] phys, input logic [5:0] old);
        rob.dispatch_valid       = 1'b1;
        rob.dispatch_has_rd      = has_rd;
        rob.dispatch_rd          = rd;
        rob.dispatch_phys_rd     = phys;
        rob.dispatch_old_phys_rd = old;
    endtask

    task automatic comp(input logic [TAG_W-1:0] tag);
        rob.complete_valid = 1'b1;
        rob.complete_tag   = tag;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        tests = 0; fails = 0; check_en = 1'b0;
        reset_n = 1'b0;
        rob.dispatch_valid = 1'b0; rob.dispatch_has_rd = 1'b0;
        rob.dispatch_rd = 5'd0; rob.dispatch_phys_rd = 6'd0;
        rob.dispatch_old_phys_rd = 6'd0;
        rob.complete_valid = 1'b0; rob.complete_tag = 4'd0;
        tick(); tick();
        reset_n = 1'b1;
        check_en = 1'b1;

        check("rst_count", 32'(rob.rob_count), 32'd0);
        check("rst_empty", 32'(rob.rob_empty), 32'd1);
        check("rst_ready", 32'(rob.dispatch_ready), 32'd1);
        check("rst_rphys", 32'(rob.retire_phys_reg), 32'd0);

        // Out-of-order completion, in-order retire
        for (int i = 0; i < 3; i++) begin
            disp(1'b1, 5'(3 + i), 6'(32 + i), 6'(3 + i));
            tick();
        end
        idle();
        comp(4'd2); tick();
        comp(4'd1); tick();
        check("ooo_noret1", 32'(rob.retire_inst), 32'd0);
        comp(4'd0); tick();
        check("ooo_noret0", 32'(rob.retire_inst), 32'd0);
        idle(); tick();
        check("ooo_rv0", 32'(rob.retire_valid), 32'd1);
        check("ooo_rp0", 32'(rob.retire_phys_reg), 32'd3);
        check("ooo_rn0", 32'(rob.retire_new_phys), 32'd32);
        tick();
        check("ooo_rp1", 32'(rob.retire_phys_reg), 32'd4);
        check("ooo_rn1", 32'(rob.retire_new_phys), 32'd33);
        tick();
        check("ooo_rp2", 32'(rob.retire_phys_reg), 32'd5);
        check("ooo_rn2", 32'(rob.retire_new_phys), 32'd34);
        check("ooo_cnt", 32'(rob.rob_count), 32'd0);
        tick();
        check("ooo_hold_rv", 32'(rob.retire_valid), 32'd0);
        check("ooo_hold_rp", 32'(rob.retire_phys_reg), 32'd5);

        // Reset mid-stream with 5 entries queued
        for (int i = 0; i < 5; i++) begin
            disp(1'b1, 5'(10 + i), 6'(40 + i), 6'(10 + i));
            tick();
        end
        idle();
        check("pre_rst_cnt", 32'(rob.rob_count), 32'd5);
        reset_n = 1'b0;
        #1;
        check("mid_rst_cnt", 32'(rob.rob_count), 32'd0);
        check("mid_rst_empty", 32'(rob.rob_empty), 32'd1);
        check("mid_rst_rv", 32'(rob.retire_valid), 32'd0);
        check("mid_rst_tag", 32'(rob.dispatch_tag), 32'd0);
        tick(); tick();
        reset_n = 1'b1;

        // No-rd entry at tag 0
        check("nord_tag", 32'(rob.dispatch_tag), 32'd0);
        disp(1'b0, 5'd7, 6'd40, 6'd9); tick();
        idle(); comp(4'd0); tick();
        idle(); tick();
        check("nord_ri", 32'(rob.retire_inst), 32'd1);
        check("nord_rv", 32'(rob.retire_valid), 32'd0);
        check("nord_cnt", 32'(rob.rob_count), 32'd0);

        // Full and wrap
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            disp(1'b1, 5'(i), 6'(32 + i), 6'(i));
            tick();
        end
        check("full_full", 32'(rob.rob_full), 32'd1);
        check("full_ready", 32'(rob.dispatch_ready), 32'd0);
        disp(1'b1, 5'd31, 6'd63, 6'd31); tick();
        check("full_17th_cnt", 32'(rob.rob_count), 32'd16);
        idle(); comp(4'd0); tick();
        check("full_stall_cnt", 32'(rob.rob_count), 32'd16);
        idle(); tick();
        check("wrap_rp", 32'(rob.retire_phys_reg), 32'd0);
        check("wrap_tag", 32'(rob.dispatch_tag), 32'd0);
        disp(1'b1, 5'd20, 6'd50, 6'd21); tick();
        idle();
        check("wrap_cnt", 32'(rob.rob_count), 32'd16);

        // Simultaneous dispatch, retire and middle completion at count 4
        do_reset();
        for (int i = 0; i < 4; i++) begin
            disp(1'b1, 5'(i + 1), 6'(48 + i), 6'(16 + i));
            tick();
        end
        idle(); comp(4'd0); tick();
        disp(1'b1, 5'd9, 6'd60, 6'd25); comp(4'd2); tick();
        check("sim_cnt", 32'(rob.rob_count), 32'd4);
        check("sim_ri", 32'(rob.retire_inst), 32'd1);
        idle(); comp(4'd1); tick();
        check("sim_noret", 32'(rob.retire_inst), 32'd0);
        idle(); tick();
        check("sim_ret1", 32'(rob.retire_phys_reg), 32'd17);
        tick();
        check("sim_mid_done", 32'(rob.retire_inst), 32'd1);
        check("sim_ret2", 32'(rob.retire_phys_reg), 32'd18);
        tick();
        check("sim_head3_wait", 32'(rob.retire_inst), 32'd0);
        comp(4'd3); tick();
        idle(); tick();
        check("sim_ret3", 32'(rob.retire_phys_reg), 32'd19);
        tick();
        check("sim_new_not_done", 32'(rob.retire_inst), 32'd0);
        check("sim_cnt1", 32'(rob.rob_count), 32'd1);

        // Spurious completion of an empty slot, then dispatch into it
        comp(4'd5); tick();
        idle(); disp(1'b1, 5'd11, 6'd61, 6'd26); tick();
        idle(); comp(4'd4); tick();
        idle(); tick();
        check("spur_ret4", 32'(rob.retire_phys_reg), 32'd25);
        tick();
        check("spur_not_done", 32'(rob.retire_inst), 32'd0);
        check("spur_cnt", 32'(rob.rob_count), 32'd1);
        // Completion of the tail slot in the same cycle it is dispatched
        disp(1'b1, 5'd12, 6'd62, 6'd27); comp(4'd6); tick();
        idle(); comp(4'd5); tick();
        idle(); tick();
        check("same_ret5", 32'(rob.retire_phys_reg), 32'd26);
        tick();
        check("same_edge_ignored", 32'(rob.retire_inst), 32'd0);
        comp(4'd6); tick();
        idle(); tick();
        check("drain_rp", 32'(rob.retire_phys_reg), 32'd27);
        check("drain_empty", 32'(rob.rob_empty), 32'd1);
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
